// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size and FSM
// state encodings, plus the lane extract/merge helpers that sit between
// a 32-bit memory word and a byte/half/word access.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_e;

    // An access is rejected when it is not naturally aligned to its size,
    // or when it uses the reserved size encoding.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        logic r;
        case (sz)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = off[0];
            SZ_WORD: r = (off != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Pull the addressed little-endian lane out of a word and extend it.
    function automatic logic [WORD_W-1:0] extract_lane(input logic [WORD_W-1:0] word,
                                                      input logic [1:0]        off,
                                                      input size_e             sz,
                                                      input logic              sext);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [WORD_W-1:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of a word with right-justified store data.
    function automatic logic [WORD_W-1:0] merge_lanes(input logic [WORD_W-1:0] word,
                                                     input logic [WORD_W-1:0] data,
                                                     input logic [1:0]        off,
                                                     input size_e             sz);
        logic [WORD_W-1:0] r;
        r = word;
        case (sz)
            SZ_BYTE: begin
                case (off)
                    2'd0:    r[7:0]   = data[7:0];
                    2'd1:    r[15:8]  = data[7:0];
                    2'd2:    r[23:16] = data[7:0];
                    default: r[31:24] = data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1])
                    r[31:16] = data[15:0];
                else
                    r[15:0] = data[15:0];
            end
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word-wide data memory with synchronous read and write.
// Only the read register is reset; the array keeps its contents.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Word write; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we)
            mem[addr] <= wdata;
    end

    // Read register only loads on reads, so it holds across write cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (en && !we)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: byte/half/word loads and stores on a
// word-wide RAM, with read-modify-write for sub-word stores and a
// one-cycle done pulse carrying rdata/err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err
);

    state_e            state;
    size_e             req_size;
    logic [1:0]        req_off;
    logic [ADDR_W-1:0] req_widx;
    logic              accept;
    logic              bad_access;
    logic              unused_addr_bits;

    logic [1:0]        lat_off;
    size_e             lat_size;
    logic              lat_sext;
    logic [WORD_W-1:0] lat_wdata;
    logic [ADDR_W-1:0] lat_widx;
    logic              load_pend;
    logic [WORD_W-1:0] rdata_q;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_q;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] loaded;

    assign req_size         = size_e'(size);
    assign req_off          = addr[1:0];
    assign req_widx         = addr[ADDR_W+1:2];
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    // Requests presented while reset is high never touch the memory.
    assign accept     = req && ready && !rst;
    assign bad_access = is_misaligned(req_size, req_off);

    assign merged = merge_lanes(ram_q, lat_wdata, lat_off, lat_size);
    assign loaded = extract_lane(ram_q, lat_off, lat_size, lat_sext);

    // A load result comes straight off the RAM read register in its done
    // cycle and is captured into rdata_q afterwards so it holds.
    assign rdata = load_pend ? loaded : rdata_q;

    // RAM port: the request drives it in IDLE, the latched RMW target in RMW.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = req_widx;
        ram_wdata = wdata;
        if (state == ST_RMW) begin
            ram_en    = !rst;
            ram_we    = 1'b1;
            ram_addr  = lat_widx;
            ram_wdata = merged;
        end else begin
            ram_en = accept && !bad_access;
            ram_we = we && (req_size == SZ_WORD);
        end
    end

    dmem_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_q)
    );

    // Request FSM with registered ready/done/err and request latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata_q   <= '0;
            load_pend <= 1'b0;
            lat_off   <= '0;
            lat_size  <= SZ_BYTE;
            lat_sext  <= 1'b0;
            lat_wdata <= '0;
            lat_widx  <= '0;
        end else begin
            done      <= 1'b0;
            load_pend <= 1'b0;
            if (load_pend)
                rdata_q <= loaded;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_off   <= req_off;
                        lat_size  <= req_size;
                        lat_sext  <= sext;
                        lat_wdata <= wdata;
                        lat_widx  <= req_widx;
                        if (bad_access) begin
                            done    <= 1'b1;
                            err     <= 1'b1;
                            rdata_q <= '0;
                        end else if (!we) begin
                            done      <= 1'b1;
                            err       <= 1'b0;
                            load_pend <= 1'b1;
                        end else if (req_size == SZ_WORD) begin
                            done    <= 1'b1;
                            err     <= 1'b0;
                            rdata_q <= '0;
                        end else begin
                            state <= ST_RMW;
                            ready <= 1'b0;
                        end
                    end
                end
                ST_RMW: begin
                    state   <= ST_IDLE;
                    ready   <= 1'b1;
                    done    <= 1'b1;
                    err     <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: word/sub-word stores and loads,
// misaligned rejects, address aliasing and reset during read-modify-write.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    int total = 0;
    int bad   = 0;

    // 100 MHz clock.
    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W(10)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .we   (we),
        .size (size),
        .sext (sext),
        .addr (addr),
        .wdata(wdata),
        .ready(ready),
        .done (done),
        .rdata(rdata),
        .err  (err)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request starting #1 after a rising edge, wait for accept and
    // for done (both bounded), then check latency, err and rdata.
    task automatic applyStimulus(input string       tag,
                                 input logic        w,
                                 input logic [1:0]  sz,
                                 input logic        sx,
                                 input logic [31:0] a,
                                 input logic [31:0] d,
                                 input int          expLat,
                                 input logic        expErr,
                                 input logic [31:0] expData);
        int waitCnt;
        int lat;
        waitCnt = 0;
        lat     = 1;
        req   = 1'b1;
        we    = w;
        size  = sz;
        sext  = sx;
        addr  = a;
        wdata = d;
        while (!ready && waitCnt < 10) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (!ready) begin
            checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
            req = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        if (expLat == 2)
            checkOutput({tag, "_busy_ready"}, {31'b0, ready}, 32'd0);
        while (!done && lat < 5) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_err"}, {31'b0, err}, {31'b0, expErr});
        checkOutput({tag, "_rdata"}, rdata, expData);
    endtask

    initial begin
        rst   = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        size  = 2'b00;
        sext  = 1'b0;
        addr  = '0;
        wdata = '0;

        #3;
        checkOutput("reset_ready", {31'b0, ready}, 32'd1);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_err", {31'b0, err}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word store then back-to-back word load of the same word.
        applyStimulus("st_w_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, 1'b0, 32'h0);
        applyStimulus("ld_w_10", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1, 1'b0, 32'hDEADBEEF);

        // Byte store through RMW, only the low byte of wdata lands in lane 1.
        applyStimulus("st_b_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h1234567F, 2, 1'b0, 32'h0);
        applyStimulus("ld_w_10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 1'b0, 32'hDEAD7FEF);

        // Sub-word loads with and without sign extension.
        applyStimulus("ld_b_13_s", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, 1'b0, 32'hFFFFFFDE);
        @(posedge clk);
        #1;
        checkOutput("hold_done", {31'b0, done}, 32'd0);
        checkOutput("hold_rdata", rdata, 32'hFFFFFFDE);
        applyStimulus("ld_b_13_z", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1, 1'b0, 32'h000000DE);
        applyStimulus("ld_h_12_s", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1, 1'b0, 32'hFFFFDEAD);
        applyStimulus("ld_h_10_s", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1, 1'b0, 32'h00007FEF);
        applyStimulus("ld_b_10_s", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1, 1'b0, 32'hFFFFFFEF);
        applyStimulus("ld_w_10_sx", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1, 1'b0, 32'hDEAD7FEF);

        // Misaligned and reserved accesses leave memory alone.
        applyStimulus("st_w_20", 1'b1, 2'b10, 1'b1, 32'h20, 32'hCAFEF00D, 1, 1'b0, 32'h0);
        applyStimulus("mis_st_h_21", 1'b1, 2'b01, 1'b0, 32'h21, 32'h00001111, 1, 1'b1, 32'h0);
        applyStimulus("mis_ld_w_06", 1'b0, 2'b10, 1'b1, 32'h06, 32'h0, 1, 1'b1, 32'h0);
        applyStimulus("mis_rsvd_10", 1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, 1, 1'b1, 32'h0);
        applyStimulus("ld_w_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 1'b0, 32'hCAFEF00D);
        applyStimulus("ld_w_10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 1'b0, 32'hDEAD7FEF);

        // Half store into the upper half, then read back pieces.
        applyStimulus("st_h_22", 1'b1, 2'b01, 1'b1, 32'h22, 32'hAAAABEEF, 2, 1'b0, 32'h0);
        applyStimulus("ld_w_20b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 1'b0, 32'hBEEFF00D);
        applyStimulus("ld_b_22_z", 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 1, 1'b0, 32'h000000EF);

        // High address bits are ignored, so 0x1000 aliases word 0.
        applyStimulus("st_w_1000", 1'b1, 2'b10, 1'b0, 32'h1000, 32'h13579BDF, 1, 1'b0, 32'h0);
        applyStimulus("ld_w_0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1, 1'b0, 32'h13579BDF);

        // Reset in the middle of an RMW abandons the write.
        applyStimulus("st_w_40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 1, 1'b0, 32'h0);
        applyStimulus("ld_w_40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1, 1'b0, 32'h11223344);
        req   = 1'b1;
        we    = 1'b1;
        size  = 2'b00;
        sext  = 1'b0;
        addr  = 32'h40;
        wdata = 32'h000000AA;
        @(posedge clk);
        #1;
        req = 1'b0;
        checkOutput("rmw_ready", {31'b0, ready}, 32'd0);
        checkOutput("rmw_done", {31'b0, done}, 32'd0);
        checkOutput("rmw_rdata_hold", rdata, 32'h11223344);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_ready", {31'b0, ready}, 32'd1);
        checkOutput("rst_mid_done", {31'b0, done}, 32'd0);
        checkOutput("rst_mid_err", {31'b0, err}, 32'd0);
        checkOutput("rst_mid_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_no_done", {31'b0, done}, 32'd0);
        end
        applyStimulus("ld_w_40_after_rst", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1, 1'b0, 32'h11223344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
